// File: rtl/julia_pixel_sched.sv
// Julia frame scheduler: walks the render window, dispatches pixel jobs to an engine pool
// and writes round-robin collected iteration counts to the framebuffer. Option: JULIA_SCHED_PERF_EN.
module julia_pixel_sched #(
  parameter int N_ENG  = 4,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int ITER_W = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [31:0]              x_min,
  input  logic [31:0]              y_max,
  input  logic [31:0]              step,
  output logic                     busy,
  output logic                     frame_done,
  output logic [N_ENG-1:0]         eng_start,
  output logic [31:0]              eng_x,
  output logic [31:0]              eng_y,
  input  logic [N_ENG-1:0]         eng_done,
  input  logic [N_ENG*ITER_W-1:0]  eng_iter,
  output logic [N_ENG-1:0]         eng_ack,
  output logic                     fb_we,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [7:0]               fb_data,
  input  logic                     fb_ready,
  output logic [1:0]               fsm_state
`ifdef JULIA_SCHED_PERF_EN
  ,
  output logic [31:0]              frame_cycles
`endif
);

  localparam int IW   = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam int PX_W = (H_RES > 1) ? $clog2(H_RES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [31:0]       x_min_r, step_r, cur_x, cur_y;
  logic [PX_W-1:0]   px;
  logic [ADDR_W-1:0] addr;
  logic [N_ENG-1:0]  busy_map;
  logic [IW-1:0]     rr_ptr;
  logic [ADDR_W-1:0] tag [N_ENG];

  logic              disp_vld, grant_vld, collect_en, last_px, drain_exit;
  logic [IW-1:0]     disp_idx, grant_idx;
  logic [N_ENG-1:0]  elig, cand, disp_oh, grant_oh;
  logic [ITER_W-1:0] iter_sel;
  int                j;

  assign fsm_state  = state;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  // Valid/ready: fb_we is the valid; a write transfers on an edge where fb_we && fb_ready,
  // and fb_addr/fb_data hold steady until then. eng_done/eng_ack follow the same pairing.
  assign elig       = ~busy_map & ~eng_ack;
  assign cand       = busy_map & eng_done;
  assign collect_en = ((state == S_RUN) || (state == S_DRAIN)) && (!fb_we || fb_ready);
  assign last_px    = (addr == ADDR_W'(H_RES * V_RES - 1));
  assign drain_exit = (state == S_DRAIN) && (busy_map == '0) && !fb_we;

  always_comb begin
    disp_vld = 1'b0;
    disp_idx = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (!disp_vld && elig[i]) begin
        disp_vld = 1'b1;
        disp_idx = IW'(i);
      end
    end
    if (state != S_RUN) disp_vld = 1'b0;
  end

  // Round-robin search starts at the engine after the last one granted.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    j = 0;
    for (int k = 0; k < N_ENG; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_ENG) j = j - N_ENG;
      if (!grant_vld && cand[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j);
      end
    end
    if (!collect_en) grant_vld = 1'b0;
  end

  assign disp_oh  = disp_vld  ? (N_ENG'(1) << disp_idx)  : '0;
  assign grant_oh = grant_vld ? (N_ENG'(1) << grant_idx) : '0;
  assign iter_sel = eng_iter[grant_idx*ITER_W +: ITER_W];

  always_ff @(posedge clk) begin
    if (disp_vld) tag[disp_idx] <= addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x_min_r   <= '0;
      step_r    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      px        <= '0;
      addr      <= '0;
      busy_map  <= '0;
      rr_ptr    <= '0;
      eng_start <= '0;
      eng_ack   <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      eng_start <= disp_oh;
      eng_ack   <= grant_oh;
      busy_map  <= (busy_map | disp_oh) & ~grant_oh;

      if (disp_vld) begin
        eng_x <= cur_x;
        eng_y <= cur_y;
        addr  <= addr + ADDR_W'(1);
        if (px == PX_W'(H_RES - 1)) begin
          px    <= '0;
          cur_x <= x_min_r;
          cur_y <= cur_y - step_r;
        end else begin
          px    <= px + PX_W'(1);
          cur_x <= cur_x + step_r;
        end
      end

      if (grant_vld) begin
        fb_we   <= 1'b1;
        fb_addr <= tag[grant_idx];
        fb_data <= (iter_sel > ITER_W'(255)) ? 8'hFF : iter_sel[7:0];
        rr_ptr  <= (grant_idx == IW'(N_ENG - 1)) ? '0 : grant_idx + IW'(1);
      end else if (fb_ready) begin
        fb_we <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state   <= S_RUN;
            x_min_r <= x_min;
            step_r  <= step;
            cur_x   <= x_min;
            cur_y   <= y_max;
            px      <= '0;
            addr    <= '0;
          end
        end
        S_RUN:   if (disp_vld && last_px) state <= S_DRAIN;
        S_DRAIN: if (drain_exit) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JULIA_SCHED_PERF_EN
  logic [31:0] cyc_cnt, cyc_next;

  assign cyc_next = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      if ((state == S_IDLE) && frame_start) cyc_cnt <= '0;
      else if ((state == S_RUN) || (state == S_DRAIN)) cyc_cnt <= cyc_next;
      if (drain_exit) frame_cycles <= cyc_next;
    end
  end
`endif

endmodule

// File: doc/julia_pixel_sched.md
# julia_pixel_sched

Frame-level scheduler that walks every pixel of a render window and maps each pixel to a Q16.16 complex start point. It dispatches each pixel job to the first idle engine in a pool of N_ENG Julia iteration engines. It collects finished iteration counts with round-robin arbitration and writes them to the framebuffer write port. It sits between the frame/viewport control logic and the iteration-engine array, in front of the framebuffer.

## Interface
- N_ENG, 4: number of iteration engines, 1..8
- H_RES, 320: pixels per line
- V_RES, 240: lines per frame
- ADDR_W, 17: framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- ITER_W, 9: engine iteration-count width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse: start rendering a frame
- x_min  in  32  Q16.16 real coordinate of pixel column 0
- y_max  in  32  Q16.16 imaginary coordinate of line 0
- step  in  32  Q16.16 coordinate increment per pixel/line
- busy  out  1  high while not IDLE
- frame_done  out  1  one-cycle pulse at frame completion
- eng_start  out  N_ENG  one-hot start pulse per engine
- eng_x, eng_y  out  32 each  start point, shared bus, valid with eng_start
- eng_done  in  N_ENG  engine result valid, held until ack
- eng_iter  in  N_ENG·ITER_W  per-engine count; slice i = bits [i·ITER_W +: ITER_W]
- eng_ack  out  N_ENG  one-hot result-consumed pulse
- fb_we  out  1  write valid, held until accepted
- fb_addr  out  ADDR_W  pixel address
- fb_data  out  8  mapped iteration count
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN: on frame_start. Latch x_min/y_max/step; clear px, py, addr; set cur_x=x_min, cur_y=y_max.
  - RUN → DRAIN: when the last pixel (addr = H_RES·V_RES−1) is dispatched.
  - DRAIN → DONE: when busy_map==0 and the fb output slot is empty.
  - DONE → IDLE: after one cycle, with frame_done=1 in DONE.
- frame_start outside IDLE: ignored.
- Engine protocol:
  - Engine i is eligible for dispatch when busy_map[i]==0 and eng_ack[i]==0.
  - Dispatch targets the lowest-index eligible engine, at most one per cycle, RUN only.
  - On dispatch: eng_start[i]=1 for one cycle with eng_x=cur_x, eng_y=cur_y; set busy_map[i]; store tag[i]=addr.
  - Then advance. If px==H_RES−1: px=0, py+=1, cur_x=x_min, cur_y−=step. Otherwise px+=1, cur_x+=step. addr+=1 in both cases.
- Coordinate arithmetic is 32-bit two's-complement, wrapping, with no saturation.
- Collection:
  - Candidates are engines with busy_map[i] && eng_done[i]. eng_done from non-busy engines is ignored.
  - Round-robin grant: priority starts at the index after the last grant; reset pointer = 0.
  - A grant occurs only when the output slot is free: fb_we==0, or fb_we && fb_ready this cycle.
  - On grant: load fb_addr=tag[i] and fb_data = (eng_iter_i > 255) ? 8'hFF : eng_iter_i[7:0]; set fb_we=1; pulse eng_ack[i]; clear busy_map[i].
- Collection runs in RUN and DRAIN, and is independent of dispatch (both may occur in one cycle).
- Pixel writes may complete out of order; each address is written exactly once per frame.

## Timing
- Reset values: busy=0, frame_done=0, eng_start=0, eng_ack=0, eng_x=eng_y=0, fb_we=0, fb_addr=0, fb_data=0; state IDLE, busy_map=0, RR pointer=0.
- Reset mid-frame returns to IDLE immediately. In-flight results are discarded: the engines are reset by the same rst.
- frame_start sampled at edge E0 → busy=1 from E0; first eng_start pulse after E1 (one idle cycle).
- Dispatch throughput: 1 job/cycle while an engine is eligible.
- Collection throughput: 1 result/cycle with fb_ready held high.
- Ack latency: eng_done[i] high and sampled at edge Ek with grant → eng_ack[i] and fb_we high after Ek. Engine i is eligible for redispatch after Ek+1 at the earliest.
- fb_addr/fb_data are stable while fb_we && !fb_ready.
- frame_done pulses one cycle after the DRAIN exit condition holds; busy falls in the same cycle frame_done falls.

## Configuration
- JULIA_SCHED_PERF_EN defined:
  - Adds output frame_cycles [31:0], reset 0.
  - An internal counter clears on IDLE→RUN and increments every cycle in RUN/DRAIN, saturating at 32'hFFFFFFFF.
  - Its value is copied to frame_cycles on entry to DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- N_ENG=4, H_RES=4, V_RES=2, x_min=−2.0 (32'hFFFE0000), y_max=1.0, step=0.5; ideal engines returning iter=3 after 5 cycles → addrs 0..7 each written once with data 8'h03; eng_x sequence −2.0, −1.5, −1.0, −0.5, then −2.0 with eng_y=0.5; frame_done exactly once.
- Engine returns iter=256 → fb_data=8'hFF; iter=255 → 8'hFF; iter=0 → 8'h00.
- All 4 engines assert eng_done in the same cycle, fb_ready=1 → acks granted 0, 1, 2, 3 on consecutive cycles; the next simultaneous burst is granted starting at 0 only if the pointer wrapped, i.e. pointer continuity is checked.
- fb_ready held low for 10 cycles with results pending → fb_we/addr/data stable, no eng_ack asserted, busy_map unchanged; resumes one write/cycle after release.
- rst asserted mid-RUN with 3 engines busy → all outputs at reset values asynchronously; a subsequent frame_start renders a full correct frame.
- frame_start pulsed during DRAIN → ignored, single frame_done; with JULIA_SCHED_PERF_EN defined, frame_cycles equals the bench-measured RUN+DRAIN cycle count.
